// File: rtl/slt_compare_arbiter_if.sv
// Request/response bundle for the shared signed less-than compare unit.
// The slave modport is the arbiter; the master modport is the requester/consumer side.
interface slt_compare_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [NUM_REQ*32-1:0] i_req_a;
    logic [NUM_REQ*32-1:0] i_req_b;
    logic [NUM_REQ-1:0]    i_req_unsigned;
    logic [NUM_REQ-1:0]    o_req_ready;
    logic                  o_rsp_valid;
    logic [ID_W-1:0]       o_rsp_id;
    logic                  o_rsp_lt;
    logic                  i_rsp_ready;

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_req_unsigned, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_lt
    );

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_req_unsigned, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_lt
    );
endinterface

// File: rtl/slt_compare_arbiter.sv
// Round-robin arbiter sharing one 32-bit signed less-than unit among NUM_REQ requesters.
// The result is registered, tagged with the winner ID and held under backpressure.
module slt_compare_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    slt_compare_arbiter_if.slave io_bus
);

    localparam int unsigned NSLOT = 1 << ID_W;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_rsp_id;
    logic            r_rsp_lt;

    logic [NSLOT-1:0] w_valid;
    logic [NSLOT-1:0] w_uns;
    logic [31:0]      w_a [NSLOT];
    logic [31:0]      w_b [NSLOT];
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_win;
    logic             w_any;
    logic             w_slot_free;
    logic             w_accept;
    logic [NSLOT-1:0] w_grant;
    logic [31:0]      w_a_op;
    logic [31:0]      w_b_op;
    logic [32:0]      w_diff;
    logic             w_lt;

    // Unpack requesters into a power-of-two table so an ID_W index is always in range
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < NUM_REQ) begin : g_used
            assign w_valid[k] = io_bus.i_req_valid[k];
            assign w_uns[k]   = io_bus.i_req_unsigned[k];
            assign w_a[k]     = io_bus.i_req_a[32*k +: 32];
            assign w_b[k]     = io_bus.i_req_b[32*k +: 32];
        end else begin : g_pad
            assign w_valid[k] = 1'b0;
            assign w_uns[k]   = 1'b0;
            assign w_a[k]     = 32'h0;
            assign w_b[k]     = 32'h0;
        end
    end

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((32'(r_ptr) + i) % NUM_REQ);
            if (!w_any && w_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_slot_free = (r_state == ST_EMPTY) || io_bus.i_rsp_ready;
    assign w_accept    = w_any && w_slot_free && !i_reset;

    always_comb begin
        w_grant = '0;
        if (w_accept) begin
            w_grant[w_win] = 1'b1;
        end
    end

    // Unsigned compares reuse the signed unit by flipping the operand MSBs
    assign w_a_op = {w_a[w_win][31] ^ w_uns[w_win], w_a[w_win][30:0]};
    assign w_b_op = {w_b[w_win][31] ^ w_uns[w_win], w_b[w_win][30:0]};
    assign w_diff = {w_a_op[31], w_a_op} - {w_b_op[31], w_b_op};
    // Sign of the sign-extended 33-bit difference cannot overflow
    assign w_lt   = |(w_diff & 33'h1_0000_0000);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_EMPTY;
            r_ptr    <= '0;
            r_rsp_id <= '0;
            r_rsp_lt <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_FULL;
                ST_FULL:  if (!w_accept && io_bus.i_rsp_ready) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
            if (w_accept) begin
                r_rsp_id <= w_win;
                r_rsp_lt <= w_lt;
                r_ptr    <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
            end
        end
    end

    assign io_bus.o_req_ready = w_grant[NUM_REQ-1:0];
    assign io_bus.o_rsp_valid = (r_state == ST_FULL);
    assign io_bus.o_rsp_id    = r_rsp_id;
    assign io_bus.o_rsp_lt    = r_rsp_lt;

endmodule

// File: doc/slt_compare_arbiter.md
Name: slt_compare_arbiter

Overview:
- Shares a single 32-bit signed less-than compare unit among NUM_REQ requesters, for example the branch unit, the SLT/SLTU ALU path and a debug port.
- Arbitration is round-robin with a valid/ready handshake on each requester.
- The result is registered and tagged with the winning requester ID, and the output side supports backpressure.
- Unsigned compares run on the signed unit by inverting bit 31 of both operands.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_W, 2, width of the requester ID (must satisfy 2^ID_W >= NUM_REQ).

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_a  in  NUM_REQ*32  operand A; requester k uses bits [32k+31:32k].
- i_req_b  in  NUM_REQ*32  operand B, same packing as i_req_a.
- i_req_unsigned  in  NUM_REQ  per-requester: 1 = unsigned compare (SLTU), 0 = signed (SLT).
- o_req_ready  out  NUM_REQ  one-hot grant; a request is accepted when valid & ready are both 1.
- o_rsp_valid  out  1  response register holds a result.
- o_rsp_id  out  ID_W  index of the requester that owns the response.
- o_rsp_lt  out  1  1 if A < B under the requested signedness.
- i_rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Reset (async assert, synchronous deassert sampled at i_clk):
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_lt=0, o_req_ready=0.
  - Round-robin pointer = 0.
  - Reset mid-transaction discards any held response; no response is emitted after reset.
- Slot free: the response slot is free when o_rsp_valid==0 or (o_rsp_valid & i_rsp_ready).
- Grant (combinational from registered state and inputs):
  - If the slot is free and any i_req_valid is set, o_req_ready is one-hot for the first valid requester found by searching upward from the pointer, wrapping modulo NUM_REQ.
  - Otherwise o_req_ready is all zero.
  - o_req_ready never asserts for a requester whose valid is 0.
- Accept edge: on the edge where the granted requester is accepted:
  - o_rsp_valid <= 1.
  - o_rsp_id <= winner index.
  - o_rsp_lt <= compare result.
  - Pointer <= (winner+1) mod NUM_REQ.
- Compare:
  - a' = {a[31]^u, a[30:0]} and b' = {b[31]^u, b[30:0]}, where u = i_req_unsigned[winner].
  - lt = signed(a') < signed(b'), computed with the shared subtract-based compare unit.
  - Exactly one compare is done per accepted request.
  - Equal operands give lt=0.
- Latency and throughput:
  - The response is visible one cycle after acceptance.
  - Back-to-back throughput is 1 per cycle when i_rsp_ready is held 1, because the slot frees and refills on the same edge.
- Backpressure:
  - While o_rsp_valid=1 and i_rsp_ready=0, o_rsp_* hold stable, o_req_ready is all 0 and the pointer holds.
  - Requesters must hold valid and operands stable until accepted.
- Drain: if o_rsp_valid & i_rsp_ready and no request is valid, then o_rsp_valid <= 0.
- State machine, 2 states:
  - EMPTY --accept--> FULL.
  - FULL --(i_rsp_ready & accept)--> FULL.
  - FULL --(i_rsp_ready & no valid)--> EMPTY.
  - FULL --(!i_rsp_ready)--> FULL (hold).
- Requester side: a requester whose valid drops without being granted is simply skipped; there is no starvation state to clean up.
- Fairness: with all requesters continuously valid and i_rsp_ready=1, grants cycle 0,1,..,NUM_REQ-1,0,…

Test Plan:
- Reset → o_rsp_valid=0, o_req_ready=0.
- Reset release, then req0 signed A=0xFFFFFFFF (-1), B=0x00000001 → o_req_ready=01; next cycle o_rsp_valid=1, id=0, lt=1.
- req1 unsigned, same operands A=0xFFFFFFFF, B=0x00000001 → id=1, lt=0.
- Overflow case: signed A=0x80000000, B=0x7FFFFFFF → lt=1.
- Equal operands: A=B=0x12345678, signed → lt=0.
- Both requesters valid continuously, i_rsp_ready=1, 6 cycles → grants 0,1,0,1,0,1; one response per cycle with matching ids.
- Backpressure: response pending, i_rsp_ready=0 for 3 cycles with req1 valid → o_rsp_* stable, o_req_ready=00. On the 4th cycle i_rsp_ready=1 → req1 is granted on the same edge the old response drains.
- Assert i_reset asynchronously while o_rsp_valid=1 → o_rsp_valid drops immediately without waiting for a clock edge; the pointer returns to 0 and the first grant after release goes to req0.
